// File: rtl/sram_pkg.sv
// Shared types and default geometry for the SRAM controller slice.
// Holds the controller state encoding and an index-width helper.
package sram_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bits needed to index DEPTH words; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port word store: synchronous byte-enabled write, registered read.
// Read data updates only on rd_en_i and otherwise holds its last value.
module sram_array
    import sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [IDX_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                rd_en_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset; zeroing is done by the controller.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// SRAM controller: post-reset clear sequence, then one-cycle-latency reads and byte writes.
// Request stalls while an unconsumed response is held; responses stay stable until taken.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = idx_width(DEPTH);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;

    logic               in_range;
    logic               req_acc;
    logic               arr_we;
    logic               arr_rd;
    logic [NB-1:0]      arr_be;
    logic [IDX_W-1:0]   arr_addr;
    logic [DATA_W-1:0]  arr_wdata;
    logic [DATA_W-1:0]  arr_rdata;

    assign in_range  = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
    assign init_done = (state_q == ST_RUN);
    assign req_ready = init_done && (!rsp_valid_q || rsp_ready);
    assign req_acc   = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        arr_we      = 1'b0;
        arr_rd      = 1'b0;
        arr_be      = '0;
        arr_addr    = req_addr[IDX_W-1:0];
        arr_wdata   = req_wdata;

        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET) begin
                    arr_we    = 1'b1;
                    arr_be    = '1;
                    arr_addr  = clr_cnt_q;
                    arr_wdata = '0;
                    if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        clr_cnt_d = clr_cnt_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Out-of-range writes are dropped; out-of-range reads answer with an error.
                if (req_acc && req_we) begin
                    arr_we = in_range;
                    arr_be = req_be;
                end
                if (req_acc && !req_we) begin
                    arr_rd      = in_range;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !in_range;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rd_en_i (arr_rd),
        .rdata_o (arr_rdata)
    );

    // Error responses carry zero data regardless of what the array last read.
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q && rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && !rsp_err_q) ? arr_rdata : '0;

    ap_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid_q && !rsp_ready) |=> (rsp_valid_q && $stable(rsp_rdata) && $stable(rsp_err)));

endmodule

// File: tb/tb_sram_ctrl.sv
// Drives a full-depth and a half-depth controller with identical requests and
// compares both against array-based memory models.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_ready;

    logic [1:0]  rdy;
    logic [1:0]  vld;
    logic [1:0]  err;
    logic [1:0]  idone;
    logic [15:0] rd0;
    logic [15:0] rd1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [128];
    bit          m_vld [2];
    bit          m_err [2];
    logic [15:0] m_dat [2];
    bit          m_idone;

    always #5 clk = ~clk;

    sram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (rdy[0]),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (vld[0]),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rd0),
        .rsp_err   (err[0]),
        .init_done (idone[0])
    );

    sram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .CLEAR_ON_RESET(1'b1)) u_dut_small (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (rdy[1]),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (vld[1]),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rd1),
        .rsp_err   (err[1]),
        .init_done (idone[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 2; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 256 : 128;
    endfunction

    function automatic logic [15:0] dut_rdata(input int k);
        return (k == 0) ? rd0 : rd1;
    endfunction

    // One request cycle: drive at negedge, check ready, apply model at the edge, check response.
    task automatic cycle(input bit v, input bit we, input logic [7:0] a, input logic [15:0] wd,
                         input logic [1:0] be, input bit rr);
        bit exp_rdy;
        bit acc;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        rsp_ready = rr;
        #1;
        exp_rdy = m_idone && (!m_vld[0] || rr);
        check("req_ready", {31'd0, rdy[0]}, {31'd0, exp_rdy});
        check("req_ready_small", {31'd0, rdy[1]}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (acc && we && int'(a) < depth_of(k)) begin
                if (k == 0) mem0[a] = merge(mem0[a], wd, be);
                else        mem1[a] = merge(mem1[a], wd, be);
            end
            if (acc && !we) begin
                m_vld[k] = 1'b1;
                m_err[k] = int'(a) >= depth_of(k);
                if (m_err[k])   m_dat[k] = 16'h0;
                else if (k == 0) m_dat[k] = mem0[a];
                else             m_dat[k] = mem1[a];
            end else if (rr) begin
                m_vld[k] = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check(k == 0 ? "rsp_valid" : "rsp_valid_small", {31'd0, vld[k]}, {31'd0, m_vld[k]});
            if (m_vld[k]) begin
                check(k == 0 ? "rsp_rdata" : "rsp_rdata_small", {16'd0, dut_rdata(k)}, {16'd0, m_dat[k]});
                check(k == 0 ? "rsp_err" : "rsp_err_small", {31'd0, err[k]}, {31'd0, m_err[k]});
            end
        end
        @(negedge clk);
    endtask

    // Reset, optionally abort the clear after abort_at cycles, then time init_done.
    task automatic reset_and_init(input int abort_at);
        int t0;
        int t1;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", {30'd0, vld}, 32'd0);
        check("rst_rsp_err", {30'd0, err}, 32'd0);
        check("rst_rdata", {rd1, rd0}, 32'd0);
        check("rst_init_done", {30'd0, idone}, 32'd0);
        check("rst_req_ready", {30'd0, rdy}, 32'd0);
        for (int i = 0; i < 256; i++) mem0[i] = 16'h0;
        for (int i = 0; i < 128; i++) mem1[i] = 16'h0;
        m_vld[0] = 1'b0;
        m_vld[1] = 1'b0;
        m_idone  = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #1;
            check("abort_init_done", {31'd0, idone[0]}, 32'd0);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("abort_rst_init_done", {30'd0, idone}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
        end
        t0 = -1;
        t1 = -1;
        for (int c = 1; c <= 600 && t0 < 0; c++) begin
            @(posedge clk);
            #1;
            if (idone[0] && t0 < 0) t0 = c;
            if (idone[1] && t1 < 0) t1 = c;
        end
        check("init_cycles", t0, 256);
        check("init_cycles_small", t1, 128);
        m_idone = 1'b1;
        @(negedge clk);
    endtask

    task automatic sweep_reads();
        for (int a = 0; a < 256; a++) begin
            cycle(1'b1, 1'b0, 8'(a), 16'h0, 2'b00, 1'b1);
        end
        cycle(1'b0, 1'b0, 8'h0, 16'h0, 2'b00, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h0;
        req_wdata = 16'h0;
        req_be    = 2'b00;
        rsp_ready = 1'b0;
        m_idone   = 1'b0;
        @(negedge clk);

        reset_and_init(0);
        sweep_reads();

        // Full-word write then read-back on the next cycle.
        cycle(1'b1, 1'b1, 8'h10, 16'hA5C3, 2'b11, 1'b1);
        cycle(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, 1'b1);
        check("a5c3_valid", {31'd0, vld[0]}, 32'd1);
        check("a5c3_data", {16'd0, rd0}, 32'h0000A5C3);
        check("a5c3_err", {31'd0, err[0]}, 32'd0);

        // Low-byte-only write.
        cycle(1'b1, 1'b1, 8'h10, 16'h1234, 2'b01, 1'b1);
        cycle(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, 1'b1);
        check("be01_data", {16'd0, rd0}, 32'h0000A534);

        // No byte enables: nothing changes.
        cycle(1'b1, 1'b1, 8'h10, 16'hFFFF, 2'b00, 1'b1);
        cycle(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, 1'b1);
        check("be00_data", {16'd0, rd0}, 32'h0000A534);

        // Address 200 is beyond the small instance.
        cycle(1'b1, 1'b0, 8'd200, 16'h0, 2'b00, 1'b1);
        check("oor_err", {31'd0, err[1]}, 32'd1);
        check("oor_data", {16'd0, rd1}, 32'd0);
        cycle(1'b1, 1'b1, 8'd200, 16'hBEEF, 2'b11, 1'b1);
        sweep_reads();

        // Stalled response must hold; then back-to-back reads once released.
        cycle(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'h20, 16'h0, 2'b00, 1'b0);
            check("stall_data", {16'd0, rd0}, 32'h0000A534);
        end
        cycle(1'b1, 1'b0, 8'd200, 16'h0, 2'b00, 1'b1);
        cycle(1'b1, 1'b0, 8'h10, 16'h0, 2'b00, 1'b1);
        cycle(1'b0, 1'b0, 8'h0, 16'h0, 2'b00, 1'b1);
        cycle(1'b0, 1'b0, 8'h0, 16'h0, 2'b00, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(120, 135));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                  16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
        end

        // Reset with a pending response and abort the clear partway through.
        cycle(1'b1, 1'b0, 8'h05, 16'h0, 2'b00, 1'b0);
        reset_and_init(100);
        sweep_reads();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, data word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 8, address width.
REQ-003 Parameter DEPTH, default 256, number of words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter CLEAR_ON_RESET, default 1, 1 = zero all words after reset.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  word address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 req_be  in  DATA_W/8  byte write enables; bit i covers data bits 8i+7..8i.
REQ-013 rsp_valid  out  1  read response present.
REQ-014 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-015 rsp_rdata  out  DATA_W  read data.
REQ-016 rsp_err  out  1  read address was out of range (>= DEPTH).
REQ-017 init_done  out  1  clear sequence finished; block usable.

Function
REQ-018 FSM states INIT and RUN; rst forces INIT.
REQ-019 In INIT with CLEAR_ON_RESET=1, a clear counter SHALL write zero to words 0..DEPTH-1, one per cycle, then move to RUN; INIT lasts exactly DEPTH cycles.
REQ-020 With CLEAR_ON_RESET=0, INIT SHALL last one cycle; memory contents undefined.
REQ-021 init_done SHALL be 1 exactly in RUN.
REQ-022 req_ready SHALL equal init_done && (!rsp_valid || rsp_ready).
REQ-023 Accepted write with req_addr < DEPTH SHALL update only the bytes with req_be=1 at that rising edge; no response generated.
REQ-024 Accepted write with req_addr >= DEPTH SHALL be discarded silently.
REQ-025 Accepted read SHALL assert rsp_valid on the next cycle with rsp_rdata = word at req_addr and rsp_err = 0 (latency 1).
REQ-026 Accepted read with req_addr >= DEPTH SHALL return rsp_rdata = 0, rsp_err = 1.
REQ-027 rsp_valid, rsp_rdata, rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-028 Response consumed and new read accepted in the same cycle SHALL give back-to-back responses, one read per cycle.
REQ-029 A read accepted the cycle after a write to the same address SHALL return the written data.
REQ-030 rsp_valid SHALL deassert the cycle after consumption when no new read is accepted.
REQ-031 req_be = 0 on a write SHALL leave memory unchanged.

Reset
REQ-032 On rst: rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, req_ready=0, clear counter=0, state=INIT.
REQ-033 rst asserted mid-clear or with a pending response SHALL restart INIT from word 0 and drop the response.
REQ-034 Memory array itself is not reset except through the clear sequence.

Structure
REQ-035 Shared package sram_pkg SHALL hold the FSM state encoding and the default DATA_W/ADDR_W/DEPTH constants.
REQ-036 Storage SHALL be a sub-module sram_array (single port, synchronous write with per-byte enables, registered read); sram_ctrl holds FSM, clear counter and handshake.

Verification
REQ-037 Reset with DEPTH=256, CLEAR_ON_RESET=1 -> init_done rises exactly 256 cycles after rst deasserts; read of every address returns 0x0000.
REQ-038 Write 0xA5C3 to addr 0x10, be=2'b11, then read 0x10 next cycle -> rsp_valid one cycle later, rsp_rdata=0xA5C3, rsp_err=0.
REQ-039 Write 0x1234 be=2'b01 over 0xA5C3 -> read returns 0xA534.
REQ-040 Read addr 200 with DEPTH=128 -> rsp_rdata=0, rsp_err=1; write to addr 200 leaves all words unchanged.
REQ-041 Hold rsp_ready=0 for 5 cycles after a read -> req_ready=0 and response stable throughout; raising rsp_ready with a new read gives consecutive responses.
REQ-042 Assert rst at clear word 100 -> init_done stays 0, counter restarts, init_done rises 256 cycles after rst deasserts.
